// File: rtl/ma_channel_scheduler.sv
// Round-robin scheduler that time-shares one moving-average core between N_CH channels.
// Optional core-response watchdog is enabled by defining MA_SCHED_WATCHDOG_EN.
module ma_channel_scheduler #(
    parameter int N_CH = 4,
    parameter int DW   = 10,
    parameter int TMO  = 31,
    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    ch_req,
    input  logic [N_CH*DW-1:0] ch_data,
    input  logic [N_CH*2-1:0]  ch_sel,
    output logic [N_CH-1:0]    ch_ack,
    output logic [N_CH-1:0]    res_valid,
    output logic [DW-1:0]      res_data,
    output logic               res_err,
    output logic               core_strobe,
    output logic [DW-1:0]      core_data,
    output logic [1:0]         core_sel,
    output logic [CW-1:0]      core_ch,
    input  logic               core_done,
    input  logic [DW-1:0]      core_result
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_gnt;
    logic [CW-1:0]   r_last_gnt;
    logic [CW-1:0]   w_pick;
    logic [CW-1:0]   w_idx;
    logic            w_found;
    logic            w_timeout;
    logic [DW-1:0]   r_data;
    logic [1:0]      r_sel;
    logic [DW-1:0]   r_res_data;

    // Search starts one past the last served channel so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = CW'((int'(r_last_gnt) + i) % N_CH);
            if (!w_found && ch_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    if (core_done || w_timeout) w_next = S_DELIVER;
            S_DELIVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Core-facing fields are gated to zero outside ISSUE, so a reset clears them at once.
    always_comb begin
        ch_ack      = '0;
        res_valid   = '0;
        core_strobe = 1'b0;
        core_data   = '0;
        core_sel    = '0;
        core_ch     = '0;
        case (r_state)
            S_ISSUE: begin
                ch_ack[r_gnt] = 1'b1;
                core_strobe   = 1'b1;
                core_data     = r_data;
                core_sel      = r_sel;
                core_ch       = r_gnt;
            end
            S_DELIVER: res_valid[r_gnt] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_found) begin
            r_gnt  <= w_pick;
            r_data <= ch_data[w_pick*DW +: DW];
            r_sel  <= ch_sel[w_pick*2 +: 2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= CW'(N_CH - 1);
            r_res_data <= '0;
        end else begin
            if (r_state == S_DELIVER) begin
                r_last_gnt <= r_gnt;
            end
            if (r_state == S_WAIT) begin
                if (core_done) begin
                    r_res_data <= core_result;
                end else if (w_timeout) begin
                    r_res_data <= '0;
                end
            end
        end
    end

    assign res_data = r_res_data;

`ifdef MA_SCHED_WATCHDOG_EN
    localparam int TW = $clog2(TMO + 1);

    logic [TW-1:0] r_cnt;
    logic          r_res_err;

    // Counter holds the number of WAIT cycles already elapsed; the TMO-th one times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !core_done && (r_cnt == TW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_err <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (core_done) begin
                r_res_err <= 1'b0;
            end else if (w_timeout) begin
                r_res_err <= 1'b1;
            end
        end
    end

    assign res_err = r_res_err;
`else
    assign w_timeout = 1'b0;
    // Without the watchdog the error flag is constant zero; TMO has no other role here.
    assign res_err   = (TMO < 0);
`endif

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Scoreboard bench for ma_channel_scheduler: directed scenarios plus randomized traffic.
module tb_ma_channel_scheduler;

    localparam int N_CH = 4;
    localparam int DW   = 10;
    localparam int TMO  = 31;
    localparam int CW   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_CH-1:0]    ch_req;
    logic [N_CH*DW-1:0] ch_data;
    logic [N_CH*2-1:0]  ch_sel;
    logic [N_CH-1:0]    ch_ack;
    logic [N_CH-1:0]    res_valid;
    logic [DW-1:0]      res_data;
    logic               res_err;
    logic               core_strobe;
    logic [DW-1:0]      core_data;
    logic [1:0]         core_sel;
    logic [CW-1:0]      core_ch;
    logic               core_done;
    logic [DW-1:0]      core_result;

    always #5 clk = ~clk;

    ma_channel_scheduler #(.N_CH(N_CH), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_req(ch_req), .ch_data(ch_data), .ch_sel(ch_sel),
        .ch_ack(ch_ack), .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .core_strobe(core_strobe), .core_data(core_data), .core_sel(core_sel), .core_ch(core_ch),
        .core_done(core_done), .core_result(core_result)
    );

    typedef struct {
        int              ch;
        logic [DW-1:0]   val;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   gnt_log[$];
    int   ack_cyc_log[$];
    int   res_cyc_log[$];
    int   res_ch_log[$];
    int   res_err_log[$];
    int   res_cnt  = 0;
    int   cyc_n    = 0;

    int   core_lat  = 4;
    bit   core_mute = 1'b0;
    bit   spur      = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] d, input logic [1:0] s);
        return d ^ 10'h07F ^ {s ^ 2'b10, 8'h00};
    endfunction

    function automatic int rr(input logic [N_CH-1:0] req, input int last);
        for (int i = 1; i <= N_CH; i++) begin
            int k;
            k = (last + i) % N_CH;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N_CH-1:0] onehot(input int k);
        logic [N_CH-1:0] v;
        v = '0;
        if (k >= 0 && k < N_CH) v[k] = 1'b1;
        return v;
    endfunction

    // Behavioural core: answers core_lat cycles after a strobe unless muted.
    initial begin : core_model
        int            pend;
        logic [DW-1:0] pres;
        pend = 0;
        pres = '0;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            core_result = DW'($urandom);
            if (!rst_n) begin
                pend = 0;
            end else if (core_strobe) begin
                pend = core_mute ? 0 : core_lat;
                pres = core_fn(core_data, core_sel);
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_result = pres;
                end
            end else if (spur) begin
                core_done = 1'b1;
                core_result = 10'h3FF;
                spur = 1'b0;
            end
        end
    end

    // Monitor: transaction-phase reference model and scoreboard, sampled mid-cycle.
    initial begin : monitor
        bit                 idle_p, issue_p, wait_p, done_p, deliver_p;
        bit                 idle_c, issue_c, wait_c, deliver_c, to_c;
        int                 wcnt_p, wcnt_c, g, last_m;
        logic [N_CH-1:0]    req_p;
        logic [N_CH*DW-1:0] data_p;
        logic [N_CH*2-1:0]  sel_p;
        exp_t               e;
        idle_p = 1'b1; issue_p = 1'b0; wait_p = 1'b0; done_p = 1'b0; deliver_p = 1'b0;
        wcnt_p = 0; last_m = N_CH - 1; req_p = '0; data_p = '0; sel_p = '0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!rst_n) begin
                idle_p = 1'b1; issue_p = 1'b0; wait_p = 1'b0; done_p = 1'b0; deliver_p = 1'b0;
                wcnt_p = 0; last_m = N_CH - 1; req_p = '0;
                exp_q.delete();
            end else begin
                issue_c   = idle_p && (|req_p);
                idle_c    = (idle_p && !(|req_p)) || deliver_p;
                deliver_c = wait_p && done_p;
                to_c      = 1'b0;
`ifdef MA_SCHED_WATCHDOG_EN
                to_c      = wait_p && !done_p && (wcnt_p >= TMO);
`endif
                wait_c    = issue_p || (wait_p && !done_p && !to_c);
                wcnt_c    = issue_p ? 1 : (wait_c ? wcnt_p + 1 : 0);

                if (issue_c) begin
                    g = rr(req_p, last_m);
                    chk("ack_grant", 64'(ch_ack), 64'(onehot(g)));
                    chk("strobe", 64'(core_strobe), 64'(1));
                    chk("core_ch", 64'(core_ch), 64'(g));
                    chk("core_data", 64'(core_data), 64'(data_p[g*DW +: DW]));
                    chk("core_sel", 64'(core_sel), 64'(sel_p[g*2 +: 2]));
                    e.ch  = g;
                    e.val = core_fn(data_p[g*DW +: DW], sel_p[g*2 +: 2]);
                    exp_q.push_back(e);
                    gnt_log.push_back(g);
                    ack_cyc_log.push_back(cyc_n);
                end else begin
                    chk("ack_quiet", 64'(ch_ack), 64'(0));
                    chk("strobe_quiet", 64'(core_strobe), 64'(0));
                end

                if (res_valid != '0 || deliver_c || to_c) begin
                    chk("res_timing", 64'(res_valid != '0), 64'(deliver_c || to_c));
                    if (exp_q.size() == 0) begin
                        chk("sb_nonempty", 64'(res_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_valid", 64'(res_valid), 64'(onehot(e.ch)));
                        chk("res_data", 64'(res_data), to_c ? 64'(0) : 64'(e.val));
                        chk("res_err", 64'(res_err), 64'(to_c));
                        last_m = e.ch;
                        res_cnt++;
                        res_cyc_log.push_back(cyc_n);
                        res_ch_log.push_back(e.ch);
                        res_err_log.push_back(int'(res_err));
                    end
                end

                idle_p    = idle_c;
                issue_p   = issue_c;
                wait_p    = wait_c;
                wcnt_p    = wcnt_c;
                deliver_p = deliver_c || to_c;
                done_p    = core_done;
                req_p     = ch_req;
                data_p    = ch_data;
                sel_p     = ch_sel;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int k, input bit r, input logic [DW-1:0] d, input logic [1:0] s);
        ch_req[k] = r;
        ch_data[k*DW +: DW] = d;
        ch_sel[k*2 +: 2] = s;
    endtask

    task automatic wait_gnt(input int base, input int budget, input string name);
        int c;
        c = 0;
        while (gnt_log.size() <= base && c < budget) begin
            cyc(1);
            c++;
        end
        chk(name, 64'(gnt_log.size() > base), 64'(1));
    endtask

    task automatic wait_res(input int n, input int budget, input string name);
        int start, c;
        start = res_cnt;
        c = 0;
        while (res_cnt - start < n && c < budget) begin
            cyc(1);
            c++;
        end
        chk(name, 64'(res_cnt - start >= n), 64'(1));
    endtask

    task automatic drain(input string name);
        int c;
        ch_req = '0;
        cyc(2);
        c = 0;
        while (exp_q.size() != 0 && c < 60) begin
            cyc(1);
            c++;
        end
        cyc(2);
        chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch_req = '0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"}, 64'(ch_ack), 64'(0));
        chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_res_data"}, 64'(res_data), 64'(0));
        chk({tag, "_res_err"}, 64'(res_err), 64'(0));
        chk({tag, "_strobe"}, 64'(core_strobe), 64'(0));
        chk({tag, "_core_data"}, 64'(core_data), 64'(0));
        chk({tag, "_core_sel"}, 64'(core_sel), 64'(0));
        chk({tag, "_core_ch"}, 64'(core_ch), 64'(0));
    endtask

    initial begin : global_bound
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench exceeded its time bound");
    end

    initial begin : stimulus
        int base, rbase, n;
        rst_n   = 1'b0;
        ch_req  = '0;
        ch_data = '0;
        ch_sel  = '0;
        cyc(3);
        check_outputs_zero("reset");

        // Single channel, core latency 4
        rst_n = 1'b1;
        core_lat = 4;
        base = gnt_log.size();
        rbase = res_cyc_log.size();
        set_ch(0, 1'b1, 10'h155, 2'b10);
        cyc(1);
        chk("single_ack", 64'(ch_ack), 64'(4'b0001));
        chk("single_core_ch", 64'(core_ch), 64'(0));
        chk("single_core_sel", 64'(core_sel), 64'(2'b10));
        chk("single_core_data", 64'(core_data), 64'(10'h155));
        set_ch(0, 1'b0, 10'h000, 2'b00);
        cyc(4);
        chk("single_res_early", 64'(res_valid), 64'(0));
        cyc(1);
        chk("single_res_valid", 64'(res_valid), 64'(4'b0001));
        chk("single_res_data", 64'(res_data), 64'(10'h12A));
        chk("single_res_err", 64'(res_err), 64'(0));
        cyc(2);
        if (res_cyc_log.size() > rbase && ack_cyc_log.size() > base)
            chk("single_latency", 64'(res_cyc_log[rbase] - ack_cyc_log[base]), 64'(5));
        else
            chk("single_logged", 64'(res_cyc_log.size() - rbase), 64'(1));

        // Fairness from reset with all channels requesting
        do_reset();
        base = gnt_log.size();
        n = 0;
        ch_req = '1;
        while (res_cnt < 1000000 && n < 400 && (gnt_log.size() - base) < 12) begin
            for (int k = 0; k < N_CH; k++) set_ch(k, 1'b1, DW'($urandom), 2'($urandom));
            core_lat = $urandom_range(1, 6);
            cyc(1);
            n++;
        end
        chk("fair_count", 64'(gnt_log.size() - base >= 12), 64'(1));
        drain("fair_drain");
        for (int i = 0; i < 12; i++) begin
            if (base + i < gnt_log.size())
                chk("fair_order", 64'(gnt_log[base + i]), 64'(i % N_CH));
        end

        // Late arrival: ch2 raised during the WAIT of a ch1 transaction
        core_lat = 4;
        base = gnt_log.size();
        rbase = res_cyc_log.size();
        set_ch(1, 1'b1, 10'h0A3, 2'b01);
        wait_gnt(base, 20, "late_first_grant");
        set_ch(1, 1'b0, 10'h000, 2'b00);
        set_ch(2, 1'b1, 10'h2C4, 2'b11);
        wait_gnt(base + 1, 20, "late_second_grant");
        set_ch(2, 1'b0, 10'h000, 2'b00);
        drain("late_drain");
        if (gnt_log.size() >= base + 2 && res_cyc_log.size() > rbase) begin
            chk("late_ch", 64'(gnt_log[base + 1]), 64'(2));
            chk("late_ack_cycle", 64'(ack_cyc_log[base + 1]), 64'(res_cyc_log[rbase] + 2));
        end

        // Withdrawn request: ch3 pulses for one cycle while a ch0 transaction waits
        core_lat = 6;
        base = gnt_log.size();
        rbase = res_ch_log.size();
        set_ch(0, 1'b1, 10'h111, 2'b00);
        wait_gnt(base, 20, "withdraw_grant");
        set_ch(0, 1'b0, 10'h000, 2'b00);
        cyc(1);
        set_ch(3, 1'b1, 10'h3C3, 2'b01);
        cyc(1);
        set_ch(3, 1'b0, 10'h000, 2'b00);
        wait_res(1, 20, "withdraw_res");
        cyc(4);
        chk("withdraw_grants", 64'(gnt_log.size() - base), 64'(1));
        chk("withdraw_results", 64'(res_ch_log.size() - rbase), 64'(1));

        // Randomized traffic with toggling requests and variable core latency
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(0, 3) == 0) ch_req[k] = ~ch_req[k];
                ch_data[k*DW +: DW] = DW'($urandom);
                ch_sel[k*2 +: 2] = 2'($urandom);
            end
            core_lat = $urandom_range(1, 6);
            cyc(1);
        end
        drain("random_drain");

        // Stray core_done while idle must be ignored
        rbase = res_cnt;
        spur = 1'b1;
        cyc(4);
        chk("stray_done_ignored", 64'(res_cnt - rbase), 64'(0));

        // Core never answers
        core_mute = 1'b1;
        base = gnt_log.size();
        rbase = res_cyc_log.size();
        set_ch(2, 1'b1, 10'h1E1, 2'b10);
        wait_gnt(base, 20, "wd_grant");
        set_ch(2, 1'b0, 10'h000, 2'b00);
`ifdef MA_SCHED_WATCHDOG_EN
        wait_res(1, 45, "wd_res");
        if (res_cyc_log.size() > rbase) begin
            chk("wd_latency", 64'(res_cyc_log[rbase] - ack_cyc_log[base]), 64'(32));
            chk("wd_ch", 64'(res_ch_log[rbase]), 64'(2));
            chk("wd_err", 64'(res_err_log[rbase]), 64'(1));
        end
        core_mute = 1'b0;
        rbase = res_cnt;
        spur = 1'b1;
        cyc(5);
        chk("wd_late_done_ignored", 64'(res_cnt - rbase), 64'(0));
`else
        cyc(45);
        chk("wd_absent_waits", 64'(res_cyc_log.size() - rbase), 64'(0));
        core_mute = 1'b0;
`endif
        do_reset();

        // Reset in WAIT: a completed transaction first leaves res_data nonzero
        core_lat = 4;
        set_ch(0, 1'b1, 10'h155, 2'b10);
        cyc(1);
        set_ch(0, 1'b0, 10'h000, 2'b00);
        wait_res(1, 20, "prereset_res");
        cyc(2);
        chk("prereset_res_data", 64'(res_data), 64'(10'h12A));
        core_lat = 6;
        base = gnt_log.size();
        rbase = res_cnt;
        set_ch(1, 1'b1, 10'h0F0, 2'b01);
        wait_gnt(base, 20, "rstwait_grant");
        set_ch(1, 1'b0, 10'h000, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        cyc(3);
        chk("rstwait_no_result", 64'(res_cnt - rbase), 64'(0));
        base = gnt_log.size();
        for (int k = 0; k < N_CH; k++) set_ch(k, 1'b1, DW'($urandom), 2'($urandom));
        rst_n = 1'b1;
        wait_gnt(base, 10, "postreset_grant");
        if (gnt_log.size() > base)
            chk("postreset_first_ch0", 64'(gnt_log[base]), 64'(0));
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ma_channel_scheduler.md
# ma_channel_scheduler

Round-robin scheduler that time-shares one moving-average filter core between `N_CH` sample producers. It accepts per-channel strobed samples, issues them one at a time to the core with that channel's filter selection and bank index, waits for the core's result strobe, and routes the filtered value back to the originating channel. It sits between the input front-ends and the shared moving-average datapath inside the top-level wrapper.

## Interface
- `N_CH`, 4: number of requesting channels (2..8).
- `DW`, 10: sample and result width.
- `TMO`, 31: core-response watchdog limit, in clocks.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ch_req`  in  N_CH  per-channel level request; sample valid while high.
- `ch_data`  in  N_CH*DW  packed samples; channel k at `[k*DW +: DW]`.
- `ch_sel`  in  N_CH*2  packed filter_select per channel.
- `ch_ack`  out  N_CH  one-hot, one-cycle pulse: sample taken.
- `res_valid`  out  N_CH  one-hot, one-cycle pulse: `res_data` belongs to that channel.
- `res_data`  out  DW  filtered result, held until the next delivery.
- `res_err`  out  1  high with `res_valid` when the result is a watchdog fill.
- `core_strobe`  out  1  one-cycle pulse: `core_data`/`core_sel`/`core_ch` valid.
- `core_data`  out  DW  sample to core.
- `core_sel`  out  2  filter_select to core.
- `core_ch`  out  clog2(N_CH)  history bank index for the core.
- `core_done`  in  1  core result strobe.
- `core_result`  in  DW  core output, valid when `core_done` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: if any `ch_req` is high, grant the first requesting channel after `last_gnt`, searching upward with wrap-around. Latch its data, sel and index, then go to ISSUE. If no request is high, stay in IDLE.
- ISSUE: `ch_ack[g]` and `core_strobe` are both high for exactly this cycle. Go to WAIT and clear the watchdog counter.
- WAIT: on `core_done`, latch `core_result` into `res_data`, clear `res_err`, and go to DELIVER. `core_done` seen in any other state is ignored.
- DELIVER: `res_valid[g]` is high for this one cycle. Set `last_gnt <= g` and go to IDLE.
- One transaction is in flight at a time. A request that stays high after its ack is treated as a new sample, which it competes for on a later IDLE cycle.
- A request raised during ISSUE, WAIT or DELIVER is not lost. It is evaluated at the next IDLE cycle.
- A `ch_req` that drops before grant is withdrawn and produces no ack.
- Reset values:
  - outputs: all 0; `res_data` = 0; `res_err` = 0.
  - internal: state IDLE; `last_gnt` = N_CH-1, so channel 0 wins first.
- Reset asserted mid-transaction: the transaction is abandoned, and no ack or result is produced for it. The core is not notified; core history is the core's responsibility.

## Timing
- Request seen high in IDLE at cycle N gives `ch_ack` and `core_strobe` in cycle N+1.
- `core_done` at cycle M (M ≥ N+2) gives `res_valid` at M+1. The minimum request-to-result time is 3 cycles.
- Back-to-back throughput: one sample per (core latency + 3) cycles. The IDLE→ISSUE decision always costs one cycle.
- `core_done` in the same cycle as the watchdog limit: `core_done` wins and `res_err` = 0.
- Channel index width: clog2(N_CH), minimum 1.

## Configuration
- `MA_SCHED_WATCHDOG_EN` defined:
  - WAIT counts clocks.
  - If the count reaches `TMO` without `core_done`, latch `res_data` = 0, set `res_err` = 1, and go to DELIVER.
  - A `core_done` that arrives after the timeout is ignored.
- Not defined:
  - No counter exists, and WAIT waits indefinitely.
  - `res_err` is tied to 0.
  - The `TMO` parameter is unused.

## Test plan
- Single channel: ch 0 requests with data 0x155, sel 2'b10; core answers `core_done` 4 cycles after the strobe with 0x12A. Required: `core_ch`=0, `core_sel`=2'b10, `core_data`=0x155; `res_valid`=4'b0001 with 0x12A exactly 1 cycle after `core_done`.
- Fairness: all four `ch_req` held high for 12 transactions. Required: grant order 0,1,2,3,0,1,2,3,…; each `ch_ack` is one-hot and exactly one cycle wide.
- Late arrival: ch 2 raises its request during WAIT of a ch 1 transaction. Required: ch 2 is granted in the IDLE cycle immediately after ch 1's DELIVER, with no extra cycle.
- Withdrawn request: ch 3 pulses `ch_req` for 1 cycle while the scheduler is in WAIT. Required: no `ch_ack[3]` and no `res_valid[3]`.
- Watchdog (macro defined, `TMO`=31): the core never asserts `core_done`. Required: `res_valid` for the granted channel with `res_data`=0 and `res_err`=1 at 32 cycles after ISSUE. A later `core_done` produces no output. Without the macro, the scheduler stays in WAIT.
- Reset in WAIT: pull `rst_n` low mid-transaction. Required: all outputs read 0 immediately (asynchronously). After release, channel 0 is granted first when all channels request.
